rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8.sv | 167 ++++++++++++++++
 tb/tb_rr_arbiter_8.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- eight-requester round-robin arbiter with registered grant.
//
// A two-state FSM (IDLE / OWNED) hands the shared resource to one requester
// at a time. Arbitration starts at the rotating pointer ptr. After a release
// the pointer moves one past the previous owner, so every active requester is
// served in turn. At least one IDLE cycle always separates two grants.
//
// Optional feature: define RR_ARB_TIMEOUT_EN to compile in a grant-hold
// watchdog. It forces a release after TIMEOUT_CYCLES owned cycles and pulses
// timeout. Without the macro, timeout is tied to 0 and grants are held until
// the owner releases them.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit in owned cycles (2..255). Used only with
//                   RR_ARB_TIMEOUT_EN.
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        synchronous, active-low reset
//   req[7:0]     per-requester request, held high until served
//   done         release pulse from the owner; ignored in IDLE
//   grant[7:0]   registered one-hot grant; all-zero when there is no owner
//   grant_idx    registered index of the current (or last) owner
//   grant_valid  registered; high while a grant is held
//   timeout      registered one-cycle pulse on a forced release
module rr_arbiter_8 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [7:0] grant_reg, grant_next;
  logic [2:0] grant_idx_reg, grant_idx_next;
  logic       grant_valid_reg, grant_valid_next;

  logic [7:0] req_rot;   // req rotated so that bit 0 is the requester at ptr
  logic [2:0] offset;    // search-order distance of the winner from ptr
  logic [2:0] sel_idx;
  logic       rel_normal;
  logic       rel_forced;
  logic       rel_any;

  // Rotation: 3-bit index arithmetic wraps modulo 8.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi] = req[ptr_reg + 3'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the first hit in search order.
  always_comb begin
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) offset = 3'(k);
    end
  end

  assign sel_idx    = ptr_reg + offset;
  // Owner releases explicitly or by dropping its request; both together
  // still count as one release.
  assign rel_normal = done | ~req[grant_idx_reg];
  assign rel_any    = rel_normal | rel_forced;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic       timeout_reg, timeout_next;

  // The counter sits at zero throughout IDLE, so it reads 0 in the first
  // owned cycle and TIMEOUT_CYCLES-1 in the last one allowed.
  assign hold_cnt_next = (state_reg == OWNED) ? hold_cnt_reg + 8'd1 : 8'd0;
  assign rel_forced    = (hold_cnt_reg == HOLD_LAST);
  // A normal release in the same cycle wins, so no pulse is produced.
  assign timeout_next  = (state_reg == OWNED) & rel_forced & ~rel_normal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_reg <= 8'd0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign timeout = timeout_reg;
`else
  assign rel_forced = 1'b0;
  assign timeout    = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= 3'd0;
      grant_reg       <= 8'h00;
      grant_idx_reg   <= 3'd0;
      grant_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      grant_reg       <= grant_next;
      grant_idx_reg   <= grant_idx_next;
      grant_valid_reg <= grant_valid_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req)   state_next = OWNED;
      OWNED:   if (rel_any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and the pointer.
  always_comb begin
    grant_next       = grant_reg;
    grant_idx_next   = grant_idx_reg;
    grant_valid_next = grant_valid_reg;
    ptr_next         = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          grant_next       = 8'b1 << sel_idx;
          grant_idx_next   = sel_idx;
          grant_valid_next = 1'b1;
        end else begin
          grant_next       = 8'h00;
          grant_valid_next = 1'b0;
        end
      end
      OWNED: begin
        // grant_idx is kept so the next search starts after the last owner.
        if (rel_any) begin
          grant_next       = 8'h00;
          grant_valid_next = 1'b0;
          ptr_next         = grant_idx_reg + 3'd1;
        end
      end
      default: begin
        grant_next       = 8'h00;
        grant_valid_next = 1'b0;
      end
    endcase
  end

  assign grant       = grant_reg;
  assign grant_idx   = grant_idx_reg;
  assign grant_valid = grant_valid_reg;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8 -- directed testbench for rr_arbiter_8.
// Inputs change 1 ns after each rising edge. Outputs are checked at that same
// point, so each check sees the registers loaded at the preceding edge.
// The watchdog checks depend on whether RR_ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter_8 #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all four outputs against the expected values.
  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                            input logic v, input logic to);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".grant_idx"}, {5'd0, grant_idx}, {5'd0, idx});
    chk({tag, ".grant_valid"}, {7'd0, grant_valid}, {7'd0, v});
    chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, to});
    $display("step %s: req=%02h done=%0b grant=%02h idx=%0d valid=%0b timeout=%0b",
             tag, req, done, grant, grant_idx, grant_valid, timeout);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    step();
    step();
    expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // Arbitration from ptr=0 after reset, with a 1-cycle grant latency.
    rst_n = 1'b1;
    req   = 8'h05;
    step();
    expect_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    step();
    expect_out("hold0", 8'h01, 3'd0, 1'b1, 1'b0);

    // Release via done; ptr becomes 1, so bit 2 wins.
    done = 1'b1;
    step();
    expect_out("done_release", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    expect_out("ptr1_grant2", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h00;
    step();
    expect_out("drop_release2", 8'h00, 3'd2, 1'b0, 1'b0);

    // Owner 3 ignores changes on other request bits.
    req = 8'h08;
    step();
    expect_out("own3", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h28;
    step();
    expect_out("own3_r5", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h0A;
    step();
    expect_out("own3_r1", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h2A;
    step();
    expect_out("own3_r15", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h22;
    step();
    expect_out("own3_drop", 8'h00, 3'd3, 1'b0, 1'b0);
    step();
    expect_out("ptr4_grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    step();
    expect_out("release5", 8'h00, 3'd5, 1'b0, 1'b0);

    // Full rotation with all requesting, then wrap from 7 to 0.
    rst_n = 1'b0;
    step();
    expect_out("reset2", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      step();
      expect_out($sformatf("rot_grant%0d", k), 8'(1 << k), 3'(k), 1'b1, 1'b0);
      if (k == 7) req = 8'h81;
      done = 1'b1;
      step();
      expect_out($sformatf("rot_idle%0d", k), 8'h00, 3'(k), 1'b0, 1'b0);
      done = 1'b0;
    end
    step();
    expect_out("wrap_grant0", 8'h01, 3'd0, 1'b1, 1'b0);

    // done and request drop together cause a single release.
    done = 1'b1;
    req  = 8'h80;
    step();
    expect_out("dual_release", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    expect_out("after_dual", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    step();
    expect_out("release7", 8'h00, 3'd7, 1'b0, 1'b0);

    // done in IDLE is ignored (ptr is now 0).
    done = 1'b1;
    step();
    expect_out("idle_done", 8'h00, 3'd7, 1'b0, 1'b0);
    req = 8'h04;
    step();
    expect_out("grant_with_done", 8'h04, 3'd2, 1'b1, 1'b0);
    done = 1'b0;
    step();
    expect_out("hold2", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h00;
    step();
    expect_out("release2b", 8'h00, 3'd2, 1'b0, 1'b0);

    // A requester selected in the same cycle it drops req still gets one grant.
    req = 8'h10;
    step();
    req = 8'h00;
    expect_out("drop_on_select", 8'h10, 3'd4, 1'b1, 1'b0);
    step();
    expect_out("drop_then_release", 8'h00, 3'd4, 1'b0, 1'b0);

    // Watchdog behaviour.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 8'h02;
`ifdef RR_ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      step();
      expect_out($sformatf("to_hold%0d", k), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    step();
    expect_out("to_fire", 8'h00, 3'd1, 1'b0, 1'b1);
    step();
    expect_out("to_regrant", 8'h02, 3'd1, 1'b1, 1'b0);
    step();
    expect_out("to_hold_b1", 8'h02, 3'd1, 1'b1, 1'b0);
    step();
    expect_out("to_hold_b2", 8'h02, 3'd1, 1'b1, 1'b0);
    done = 1'b1;
    step();
    expect_out("to_done_wins", 8'h00, 3'd1, 1'b0, 1'b0);
    done = 1'b0;
    step();
    expect_out("to_regrant2", 8'h02, 3'd1, 1'b1, 1'b0);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      expect_out($sformatf("no_to_hold%0d", k), 8'h02, 3'd1, 1'b1, 1'b0);
    end
`endif
    // Reset in the middle of a grant drops it with no timeout pulse.
    rst_n = 1'b0;
    step();
    expect_out("reset_mid_grant", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 8'h00;
    step();
    expect_out("after_reset", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
